iomem_debug_master: RTL and testbench

IOMEM_DEBUG_MASTER -- requirements
Module: iomem_debug_master

---
 rtl/iomem_debug_master_if.sv | 32 +++
 rtl/iomem_debug_master.sv | 138 +++++++++++++
 tb/tb_iomem_debug_master.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/iomem_debug_master_if.sv
// Host byte streams and iomem initiator bus of the debug master.
// master = the bridge block, slave = host/responder side.
interface iomem_debug_master_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    input  iomem_ready, iomem_rdata,
    output rx_ready, tx_data, tx_valid,
    output iomem_valid, iomem_wstrb,
    output iomem_addr, iomem_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    output iomem_ready, iomem_rdata,
    input  rx_ready, tx_data, tx_valid,
    input  iomem_valid, iomem_wstrb,
    input  iomem_addr, iomem_wdata
  );
endinterface

// File: rtl/iomem_debug_master.sv
// Byte-stream command bridge: decodes host read/write frames into
// single iomem bus transactions and streams the response back.
module iomem_debug_master #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  resetn,
  iomem_debug_master_if.master  bus,
  output logic                  busy
);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS,
    RESP
  } state_t;

  state_t      state;
  logic        wr;
  logic [1:0]  idx;
  logic [15:0] cnt;
  logic [23:0] sh;
  logic [1:0]  rem;
  logic        rx_fire;
  logic        tx_fire;

  // rx_ready is gated by resetn so it reads 0 throughout reset.
  assign bus.rx_ready = resetn &&
    (state == IDLE || state == ADDR || state == DATA);
  assign busy    = (state != IDLE);
  assign rx_fire = bus.rx_valid && bus.rx_ready;
  assign tx_fire = bus.tx_valid && bus.tx_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= IDLE;
      wr              <= 1'b0;
      idx             <= 2'd0;
      cnt             <= 16'd0;
      sh              <= 24'd0;
      rem             <= 2'd0;
      bus.iomem_valid <= 1'b0;
      bus.iomem_wstrb <= 4'h0;
      bus.iomem_addr  <= 32'd0;
      bus.iomem_wdata <= 32'd0;
      bus.tx_valid    <= 1'b0;
      bus.tx_data     <= 8'h00;
    end else begin
      unique case (state)
        IDLE: begin
          if (rx_fire) begin
            if (bus.rx_data == 8'h01 ||
                bus.rx_data == 8'h02) begin
              wr    <= (bus.rx_data == 8'h01);
              idx   <= 2'd0;
              state <= ADDR;
            end else begin
              bus.tx_valid <= 1'b1;
              bus.tx_data  <= 8'hEE;
              rem          <= 2'd0;
              state        <= RESP;
            end
          end
        end
        ADDR: begin
          if (rx_fire) begin
            bus.iomem_addr <= {bus.rx_data,
                               bus.iomem_addr[31:8]};
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              if (wr) begin
                state <= DATA;
              end else begin
                state           <= BUS;
                bus.iomem_valid <= 1'b1;
                bus.iomem_wstrb <= 4'h0;
                cnt             <= 16'd0;
              end
            end
          end
        end
        DATA: begin
          if (rx_fire) begin
            bus.iomem_wdata <= {bus.rx_data,
                                bus.iomem_wdata[31:8]};
            idx <= idx + 2'd1;
            if (idx == 2'd3) begin
              state           <= BUS;
              bus.iomem_valid <= 1'b1;
              bus.iomem_wstrb <= 4'hF;
              cnt             <= 16'd0;
            end
          end
        end
        BUS: begin
          // ready takes priority over an expiring timeout
          if (bus.iomem_ready) begin
            bus.iomem_valid <= 1'b0;
            bus.tx_valid    <= 1'b1;
            state           <= RESP;
            if (wr) begin
              bus.tx_data <= 8'hAA;
              rem         <= 2'd0;
            end else begin
              bus.tx_data <= bus.iomem_rdata[7:0];
              sh          <= bus.iomem_rdata[31:8];
              rem         <= 2'd3;
            end
          end else if (cnt == 16'(TIMEOUT - 1)) begin
            bus.iomem_valid <= 1'b0;
            bus.tx_valid    <= 1'b1;
            bus.tx_data     <= 8'hEE;
            rem             <= 2'd0;
            state           <= RESP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: begin
          if (tx_fire) begin
            if (rem == 2'd0) begin
              bus.tx_valid <= 1'b0;
              state        <= IDLE;
            end else begin
              bus.tx_data <= sh[7:0];
              sh          <= {8'h00, sh[23:8]};
              rem         <= rem - 2'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iomem_debug_master.sv
// Randomized scoreboard bench for iomem_debug_master with an
// abstract frame-level model and a decoupled negedge monitor.
module tb_iomem_debug_master;

  localparam int TO = 8;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          len;
  } bus_t;

  typedef struct {
    logic [7:0] b;
    bit         last;
  } tx_t;

  typedef struct {
    int          d;
    logic [31:0] data;
  } rsp_t;

  logic clk = 1'b0;
  logic resetn;
  logic busy;

  iomem_debug_master_if bus();

  iomem_debug_master #(.TIMEOUT(TO)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  bus_t exp_bus[$];
  tx_t  exp_tx[$];
  rsp_t rsp_q[$];

  int checks = 0;
  int errors = 0;
  bit rmode = 0;
  bit rgap = 0;
  int stall = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, req, $time);
    end
  endtask

  // Responder: ready pulses in valid cycle d+1; d >= TO never answers.
  initial begin
    rsp_t r;
    int vcnt;
    r = '{d: 1000, data: 32'h0};
    vcnt = 0;
    bus.iomem_ready = 1'b0;
    bus.iomem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (!resetn || !bus.iomem_valid) begin
        vcnt = 0;
        bus.iomem_ready = 1'b0;
      end else begin
        if (vcnt == 0) begin
          if (rsp_q.size() != 0) r = rsp_q.pop_front();
          else r = '{d: 1000, data: 32'h0};
        end
        vcnt++;
        bus.iomem_ready = (vcnt == r.d + 1);
      end
      bus.iomem_rdata = bus.iomem_ready ? r.data : $urandom;
    end
  end

  // Host tx side
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall > 0) begin
        bus.tx_ready = 1'b0;
        stall--;
      end else begin
        bus.tx_ready = rmode ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor
  initial begin
    bus_t cur;
    tx_t  et;
    bit   pv, pstall, pnb;
    logic [7:0] pdata;
    int   vlen;
    pv = 0; pstall = 0; pnb = 0; pdata = 0; vlen = 0;
    cur = '{addr: 0, wdata: 0, wstrb: 0, len: 0};
    forever begin
      @(negedge clk);
      #1;
      if (!resetn) begin
        pv = 0; pstall = 0; pnb = 0;
        continue;
      end
      if (bus.iomem_valid) begin
        if (!pv) begin
          vlen = 0;
          if (exp_bus.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bus act=1 exp=0 t=%0t", $time);
            cur = '{addr: bus.iomem_addr, wdata: bus.iomem_wdata,
                    wstrb: bus.iomem_wstrb, len: 0};
          end else begin
            cur = exp_bus.pop_front();
            chk("bus_addr", bus.iomem_addr, cur.addr);
            chk("bus_wstrb", 32'(bus.iomem_wstrb), 32'(cur.wstrb));
            if (cur.wstrb == 4'hF)
              chk("bus_wdata", bus.iomem_wdata, cur.wdata);
            else
              cur.wdata = bus.iomem_wdata;
          end
        end else begin
          chk("stable_addr", bus.iomem_addr, cur.addr);
          chk("stable_wdata", bus.iomem_wdata, cur.wdata);
          chk("stable_wstrb", 32'(bus.iomem_wstrb), 32'(cur.wstrb));
        end
        vlen++;
      end else if (pv) begin
        chk("valid_len", 32'(vlen), 32'(cur.len));
      end
      pv = bus.iomem_valid;

      if (pstall) begin
        chk("tx_hold_valid", 32'(bus.tx_valid), 32'd1);
        chk("tx_hold_data", 32'(bus.tx_data), 32'(pdata));
      end
      if (pnb) chk("tx_no_bubble", 32'(bus.tx_valid), 32'd1);
      pnb = 0;
      if (bus.tx_valid && bus.tx_ready) begin
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_tx act=%h exp=none t=%0t",
                   bus.tx_data, $time);
        end else begin
          et = exp_tx.pop_front();
          chk("tx_byte", 32'(bus.tx_data), 32'(et.b));
          pnb = !et.last;
        end
      end
      pstall = bus.tx_valid && !bus.tx_ready;
      pdata = bus.tx_data;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    bus.rx_data = b;
    bus.rx_valid = 1'b1;
    while (!bus.rx_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++; errors++;
      $display("FAIL rx_accept_timeout act=0 exp=1 t=%0t", $time);
    end
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    bus.rx_data = $urandom;
    if (rgap) repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Frame-level model: expectations pushed before the bytes are sent.
  task automatic issue(input logic [7:0] op, input logic [31:0] addr,
                       input logic [31:0] wdata, input int d,
                       input logic [31:0] rdata);
    bit ok;
    ok = (op == 8'h01 || op == 8'h02);
    if (ok) begin
      exp_bus.push_back('{addr: addr, wdata: wdata,
                          wstrb: (op == 8'h01) ? 4'hF : 4'h0,
                          len: (d < TO) ? d + 1 : TO});
      rsp_q.push_back('{d: d, data: rdata});
      if (d >= TO) exp_tx.push_back('{b: 8'hEE, last: 1});
      else if (op == 8'h01) exp_tx.push_back('{b: 8'hAA, last: 1});
      else
        for (int i = 0; i < 4; i++)
          exp_tx.push_back('{b: rdata[8*i +: 8], last: (i == 3)});
    end else begin
      exp_tx.push_back('{b: 8'hEE, last: 1});
    end
    send_byte(op);
    if (ok) for (int i = 0; i < 4; i++) send_byte(addr[8*i +: 8]);
    if (op == 8'h01)
      for (int i = 0; i < 4; i++) send_byte(wdata[8*i +: 8]);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || exp_tx.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++; errors++;
      $display("FAIL idle_timeout act=%0d exp=0 t=%0t",
               exp_tx.size(), $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_iomem_valid"}, 32'(bus.iomem_valid), 32'd0);
    chk({tag, "_wstrb"}, 32'(bus.iomem_wstrb), 32'd0);
    chk({tag, "_addr"}, bus.iomem_addr, 32'd0);
    chk({tag, "_wdata"}, bus.iomem_wdata, 32'd0);
    chk({tag, "_tx_valid"}, 32'(bus.tx_valid), 32'd0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rx_ready"}, 32'(bus.rx_ready), 32'd0);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #3;
    resetn = 1'b0;
    #1;
    chk_reset_vals(tag);
    bus.rx_valid = 1'b0;
    exp_bus.delete();
    exp_tx.delete();
    rsp_q.delete();
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b1;
    #1;
    chk({tag, "_rx_ready_rel"}, 32'(bus.rx_ready), 32'd1);
  endtask

  initial begin
    int n;
    logic [7:0] op;
    resetn = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data = 8'h00;
    #1;
    chk_reset_vals("por");
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("por_rx_ready_rel", 32'(bus.rx_ready), 32'd1);

    issue(8'h01, 32'h0300_0010, 32'hDEAD_BEEF, 2, 32'h0);
    issue(8'h02, 32'h0500_0000, 32'h0, 1, 32'h1234_5678);
    wait_idle();
    issue(8'h7F, 32'h0, 32'h0, 0, 32'h0);
    issue(8'h02, 32'h0000_0100, 32'h0, 100, 32'h0);
    issue(8'h02, 32'h0000_0104, 32'h0, TO - 1, 32'hCAFE_F00D);
    wait_idle();

    issue(8'h02, 32'h0000_0200, 32'h0, 0, 32'hA1B2_C3D4);
    n = 0;
    while (!bus.tx_valid && n < 200) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("stall_tx_seen", 32'(bus.tx_valid), 32'd1);
    stall = 5;
    wait_idle();

    rmode = 1;
    rgap = 1;
    for (int k = 0; k < 40; k++) begin
      n = $urandom_range(0, 9);
      if (n < 4) op = 8'h01;
      else if (n < 8) op = 8'h02;
      else begin
        op = $urandom;
        if (op == 8'h01 || op == 8'h02) op = 8'h80;
      end
      issue(op, $urandom, $urandom, $urandom_range(0, 11), $urandom);
    end
    wait_idle();
    rmode = 0;
    rgap = 0;

    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    pulse_reset("rst_addr");
    issue(8'h02, 32'h0000_0300, 32'h0, 100, 32'h0);
    repeat (3) @(negedge clk);
    pulse_reset("rst_bus");
    issue(8'h01, 32'h0300_0010, 32'hDEAD_BEEF, 2, 32'h0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("left_bus", 32'(exp_bus.size()), 32'd0);
    chk("left_tx", 32'(exp_tx.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
